ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port 8-bit RAM between three requesters: the memory programmer (P),
//  the CDEC8 core bus (C) and a debug read port (D).
//  Replaces the mode-steered muxes on the RAM address/data/clock/write-enable with a
//  one-clock, request/ack arbiter driving one RAM port. Sits between the requesters and
//  the memory instance in the CPU shell.
// PARAMETERS
//  AW  8  address width (RAM depth 2**AW)
//  DW  8  data width
// PORTS
//  clock     in   1   single system clock; RAM is clocked by the same clock
//  reset     in   1   synchronous, active-high reset
//  mode      in   1   1=program mode (P,D eligible), 0=run mode (C,D eligible)
//  p_req     in   1   programmer request; hold stable until p_ack
//  p_we      in   1   programmer write(1)/read(0)
//  p_adrs    in   AW  programmer address
//  p_wdata   in   DW  programmer write data
//  p_ack     out  1   one-cycle completion pulse to P
//  c_req     in   1   CPU request; hold stable until c_ack
//  c_we      in   1   CPU write(1)/read(0)
//  c_adrs    in   AW  CPU address
//  c_wdata   in   DW  CPU write data
//  c_ack     out  1   one-cycle completion pulse to C
//  d_req     in   1   debug read request; hold until d_ack
//  d_adrs    in   AW  debug read address
//  d_ack     out  1   one-cycle completion pulse to D
//  rd_data   out  DW  = mem_q; valid only in the cycle the owning ack is high
//  mem_adrs  out  AW  RAM address (registered)
//  mem_data  out  DW  RAM write data (registered)
//  mem_wr_en out  1   RAM write enable (registered)
//  mem_q     in   DW  RAM read data, valid one clock after the address is sampled
//  grant     out  2   owner of the in-flight access: 0=none, 1=P, 2=C, 3=D
//  busy      out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all ack, mem_wr_en, mem_adrs, mem_data and grant are 0; rr_last=D,
//   so C wins the first C/D tie.
//  Eligibility: P needs mode=1. C needs mode=0. D is always eligible.
//  Priority: P over {C,D}. C vs D is round-robin on rr_last; a winner from C/D updates rr_last.
//  FSM: IDLE -> ACCESS -> DONE -> (ACCESS | IDLE).
//   IDLE (cycle N): if any eligible req, latch the winner's adrs/wdata/we into mem_* and
//    set grant; go to ACCESS. Otherwise stay in IDLE.
//   ACCESS (N+1): mem_wr_en=we of the owner (D always 0); RAM samples at the end of N+1;
//    go to DONE.
//   DONE (N+2): mem_wr_en=0; owner's ack=1; rd_data=mem_q is the read result.
//    In the same cycle the arbiter re-arbitrates, excluding the current owner. On a winner
//    it reloads mem_* and goes to ACCESS; otherwise it goes to IDLE and grant=0.
//  Latency: 2 clocks from req sampled to ack. Peak throughput is 1 access per 2 clocks.
//  Requirements on requesters:
//   - Drop req in the ack cycle or the cycle after. Excluding the owner in DONE prevents a
//     duplicate access.
//   - Changing adrs/wdata/we while req is high is not allowed. Values latched at grant are
//     used.
//   - A req dropped after grant still completes and acks; the requester ignores the ack.
//  mode toggles mid-access: the in-flight access completes and acks. The new eligibility
//   applies from the next arbitration.
//  mem_adrs/mem_data hold their last value when idle.
//  Exactly one ack is high per cycle, at most.
//  Reset mid-access: an access in ACCESS is cut short (mem_wr_en=0 from the next edge).
//   No ack is issued.
// TESTING
//  1 reset, mode=1, P write adrs 8'h10 data 8'hA5 -> mem_wr_en=1 in N+1 only; p_ack in N+2;
//    grant=1 in N+1..N+2.
//  2 mode=0, C read 8'h10 -> c_ack in N+2 with rd_data=8'hA5; mem_wr_en stays 0.
//  3 mode=0, C and D req every cycle -> grants C,D,C,D alternate; no duplicate acks;
//    each ack 2 clocks apart.
//  4 mode=0, P req held -> never granted. Switch mode=1 -> P granted at the next arbitration
//    and C starves until mode=0.
//  5 mode 1->0 during the P write ACCESS -> the write lands and p_ack is still issued.
//  6 reset asserted in ACCESS of a C write -> no c_ack; busy=0 and all outputs 0 one clock
//    later; the next C request works normally.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundles the three requester handshakes and the single RAM port shared by the arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface ram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_adrs;
    logic [DW-1:0] p_wdata;
    logic          p_ack;

    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_adrs;
    logic [DW-1:0] c_wdata;
    logic          c_ack;

    logic          d_req;
    logic [AW-1:0] d_adrs;
    logic          d_ack;

    logic [DW-1:0] rd_data;

    logic [AW-1:0] mem_adrs;
    logic [DW-1:0] mem_data;
    logic          mem_wr_en;
    logic [DW-1:0] mem_q;

    modport slave (
        input  p_req, p_we, p_adrs, p_wdata,
        input  c_req, c_we, c_adrs, c_wdata,
        input  d_req, d_adrs,
        input  mem_q,
        output p_ack, c_ack, d_ack, rd_data,
        output mem_adrs, mem_data, mem_wr_en
    );

    modport master (
        output p_req, p_we, p_adrs, p_wdata,
        output c_req, c_we, c_adrs, c_wdata,
        output d_req, d_adrs,
        output mem_q,
        input  p_ack, c_ack, d_ack, rd_data,
        input  mem_adrs, mem_data, mem_wr_en
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Request/ack arbiter sharing one single-port RAM between the programmer (P), the CPU (C)
// and a debug read port (D). Each access takes IDLE/DONE -> ACCESS -> DONE.
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    ram_port_arbiter_if.slave   bus,
    output logic [1:0]          grant,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P    = 2'd1;
    localparam logic [1:0] OWN_C    = 2'd2;
    localparam logic [1:0] OWN_D    = 2'd3;

    state_t        state;
    state_t        state_next;
    logic [1:0]    grant_next;
    logic          rr_last_d;
    logic          rr_last_d_next;
    logic [AW-1:0] mem_adrs_reg;
    logic [AW-1:0] mem_adrs_next;
    logic [DW-1:0] mem_data_reg;
    logic [DW-1:0] mem_data_next;
    logic          mem_wr_en_reg;
    logic          mem_wr_en_next;

    logic [1:0]    exclude;
    logic          p_elig;
    logic          c_elig;
    logic          d_elig;
    logic [1:0]    winner;

    // The owner finishing in DONE is masked out so a req still held in its ack cycle
    // cannot trigger a second access.
    always_comb begin
        exclude = (state == DONE) ? grant : OWN_NONE;
        p_elig  = bus.p_req && mode  && (exclude != OWN_P);
        c_elig  = bus.c_req && !mode && (exclude != OWN_C);
        d_elig  = bus.d_req          && (exclude != OWN_D);

        winner = OWN_NONE;
        if (p_elig) begin
            winner = OWN_P;
        end else if (c_elig && d_elig) begin
            winner = rr_last_d ? OWN_C : OWN_D;
        end else if (c_elig) begin
            winner = OWN_C;
        end else if (d_elig) begin
            winner = OWN_D;
        end
    end

    always_comb begin
        state_next     = state;
        grant_next     = grant;
        rr_last_d_next = rr_last_d;
        mem_adrs_next  = mem_adrs_reg;
        mem_data_next  = mem_data_reg;
        mem_wr_en_next = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (winner != OWN_NONE) begin
                    state_next = ACCESS;
                    grant_next = winner;
                    case (winner)
                        OWN_P: begin
                            mem_adrs_next  = bus.p_adrs;
                            mem_data_next  = bus.p_wdata;
                            mem_wr_en_next = bus.p_we;
                        end
                        OWN_C: begin
                            mem_adrs_next  = bus.c_adrs;
                            mem_data_next  = bus.c_wdata;
                            mem_wr_en_next = bus.c_we;
                            rr_last_d_next = 1'b0;
                        end
                        default: begin
                            mem_adrs_next  = bus.d_adrs;
                            rr_last_d_next = 1'b1;
                        end
                    endcase
                end else begin
                    state_next = IDLE;
                    grant_next = OWN_NONE;
                end
            end
            ACCESS: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
                grant_next = OWN_NONE;
            end
        endcase
    end

    // rr_last_d resets high so the CPU wins the first C/D tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= OWN_NONE;
            rr_last_d     <= 1'b1;
            mem_adrs_reg  <= '0;
            mem_data_reg  <= '0;
            mem_wr_en_reg <= 1'b0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            rr_last_d     <= rr_last_d_next;
            mem_adrs_reg  <= mem_adrs_next;
            mem_data_reg  <= mem_data_next;
            mem_wr_en_reg <= mem_wr_en_next;
        end
    end

    assign bus.mem_adrs  = mem_adrs_reg;
    assign bus.mem_data  = mem_data_reg;
    assign bus.mem_wr_en = mem_wr_en_reg;

    // Acks decode purely from registered state, so at most one is ever high.
    assign bus.p_ack   = (state == DONE) && (grant == OWN_P);
    assign bus.c_ack   = (state == DONE) && (grant == OWN_C);
    assign bus.d_ack   = (state == DONE) && (grant == OWN_D);
    assign bus.rd_data = bus.mem_q;
    assign busy        = (state != IDLE);

endmodule
